// File: rtl/xbar_mem_peripheral_if.sv
// Crossbar peripheral-port bus: request/write fields toward the memory, ready/read data back.
// Signal suffixes are named from the peripheral's point of view.
interface xbar_mem_peripheral_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  p_req_i;
  logic [ADDR_WIDTH-1:0] p_addr_i;
  logic                  p_wen_i;
  logic [31:0]           p_wdata_i;
  logic [3:0]            p_be_i;
  logic                  p_ready_o;
  logic [31:0]           p_rdata_o;
  logic                  p_rvalid_o;

  modport master (
    output p_req_i, p_addr_i, p_wen_i, p_wdata_i, p_be_i,
    input  p_ready_o, p_rdata_o, p_rvalid_o
  );

  modport slave (
    input  p_req_i, p_addr_i, p_wen_i, p_wdata_i, p_be_i,
    output p_ready_o, p_rdata_o, p_rvalid_o
  );
endinterface

// File: rtl/xbar_mem_peripheral.sv
// Word-addressed 32-bit memory responder for one crossbar peripheral port, with LATENCY wait states.
// Optional access counters are enabled by defining XBAR_MEM_ACCESS_CNT_EN.
module xbar_mem_peripheral #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  xbar_mem_peripheral_if.slave bus,
  input  logic                 cnt_clr_i,
  output logic [CNT_WIDTH-1:0] rd_count_o,
  output logic [CNT_WIDTH-1:0] wr_count_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [31:0] r_mem [2**ADDR_WIDTH];
  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        w_ready;
  logic        w_accept;
  logic        w_rd_accept;
  logic        w_wr_accept;

  generate
    if (LATENCY == 0) begin : g_nowait
      assign w_ready = 1'b1;
    end else begin : g_wait
      state_t     r_state;
      state_t     w_state_nxt;
      logic [3:0] r_cnt;
      logic [3:0] w_cnt_nxt;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
        end
      end

      // Dropping p_req_i while waiting aborts the access without side effects.
      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready     = 1'b0;
        case (r_state)
          S_IDLE: begin
            if (bus.p_req_i) begin
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = 4'd1;
            end
          end
          S_WAIT: begin
            w_ready = (r_cnt == 4'(LATENCY));
            if (!bus.p_req_i || w_ready) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + 4'd1;
            end
          end
        endcase
      end
    end
  endgenerate

  assign w_accept    = bus.p_req_i & w_ready;
  assign w_rd_accept = w_accept & ~bus.p_wen_i;
  assign w_wr_accept = w_accept & bus.p_wen_i;

  // Memory is not reset; a write at one edge is visible to a read accepted at the next.
  always_ff @(posedge clk_i) begin
    if (w_wr_accept) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.p_be_i[i]) begin
          r_mem[bus.p_addr_i][8*i +: 8] <= bus.p_wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_accept;
      if (w_rd_accept) begin
        r_rdata <= r_mem[bus.p_addr_i];
      end
    end
  end

  assign bus.p_ready_o  = w_ready;
  assign bus.p_rdata_o  = r_rdata;
  assign bus.p_rvalid_o = r_rvalid;

`ifdef XBAR_MEM_ACCESS_CNT_EN
  logic [CNT_WIDTH-1:0] r_rd_cnt;
  logic [CNT_WIDTH-1:0] r_wr_cnt;

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (cnt_clr_i) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd_accept && (r_rd_cnt != '1)) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      if (w_wr_accept && (r_wr_cnt != '1)) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
    end
  end

  assign rd_count_o = r_rd_cnt;
  assign wr_count_o = r_wr_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr_i;
  assign rd_count_o = '0;
  assign wr_count_o = '0;
`endif

endmodule

// File: tb/tb_xbar_mem_peripheral.sv
// Self-checking bench: a LATENCY=0 instance (CNT_WIDTH=2) and a LATENCY=3 instance checked
// against a per-instance behavioural memory model, with table vectors and directed corner cases.
module tb_xbar_mem_peripheral;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  xbar_mem_peripheral_if #(.ADDR_WIDTH(AW)) busL0 ();
  xbar_mem_peripheral_if #(.ADDR_WIDTH(AW)) busL3 ();

  logic        clr0, clr3;
  logic [1:0]  rdCnt0, wrCnt0;
  logic [15:0] rdCnt3, wrCnt3;

  xbar_mem_peripheral #(.ADDR_WIDTH(AW), .LATENCY(0), .CNT_WIDTH(2)) u_l0 (
    .clk_i(clk), .rst_ni(rstN), .bus(busL0.slave), .cnt_clr_i(clr0),
    .rd_count_o(rdCnt0), .wr_count_o(wrCnt0));

  xbar_mem_peripheral #(.ADDR_WIDTH(AW), .LATENCY(3), .CNT_WIDTH(16)) u_l3 (
    .clk_i(clk), .rst_ni(rstN), .bus(busL3.slave), .cnt_clr_i(clr3),
    .rd_count_o(rdCnt3), .wr_count_o(wrCnt3));

  // Behavioural model: one memory image, last read value and access counts per instance.
  logic [31:0] modelMem [2][1024];
  logic [31:0] modelRdata [2];
  int          modelRd [2];
  int          modelWr [2];

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic        wen;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] expRdata;
    logic        expRvalid;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic int satCnt(input int d, input int n);
    int lim;
    lim = (d == 0) ? 3 : 65535;
`ifndef XBAR_MEM_ACCESS_CNT_EN
    lim = 0;
`endif
    return (n > lim) ? lim : n;
  endfunction

  task automatic driveBus(input int d, input logic req, input logic wen, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input logic clr);
    if (d == 0) begin
      busL0.p_req_i = req; busL0.p_wen_i = wen; busL0.p_addr_i = addr;
      busL0.p_wdata_i = wdata; busL0.p_be_i = be; clr0 = clr;
    end else begin
      busL3.p_req_i = req; busL3.p_wen_i = wen; busL3.p_addr_i = addr;
      busL3.p_wdata_i = wdata; busL3.p_be_i = be; clr3 = clr;
    end
  endtask

  function automatic logic [31:0] getReady(input int d);
    return {31'd0, (d == 0) ? busL0.p_ready_o : busL3.p_ready_o};
  endfunction
  function automatic logic [31:0] getRvalid(input int d);
    return {31'd0, (d == 0) ? busL0.p_rvalid_o : busL3.p_rvalid_o};
  endfunction
  function automatic logic [31:0] getRdata(input int d);
    return (d == 0) ? busL0.p_rdata_o : busL3.p_rdata_o;
  endfunction
  function automatic logic [31:0] getRdCnt(input int d);
    return (d == 0) ? {30'd0, rdCnt0} : {16'd0, rdCnt3};
  endfunction
  function automatic logic [31:0] getWrCnt(input int d);
    return (d == 0) ? {30'd0, wrCnt0} : {16'd0, wrCnt3};
  endfunction

  task automatic modelAccess(input int d, input logic wen, input logic [9:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic clr,
                             output logic [31:0] expRdata, output logic expRvalid);
    if (wen) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) modelMem[d][addr][8*b +: 8] = wdata[8*b +: 8];
      modelWr[d]++;
    end else begin
      modelRdata[d] = modelMem[d][addr];
      modelRd[d]++;
    end
    if (clr) begin
      modelRd[d] = 0;
      modelWr[d] = 0;
    end
    expRdata  = modelRdata[d];
    expRvalid = !wen;
  endtask

  // One full access: junk fields during wait cycles, real fields in the accept cycle.
  task automatic applyStimulus(input int d, input logic wen, input logic [9:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic clr, input logic useTable,
                               input logic [31:0] tabRdata, input logic tabRvalid, input string name);
    int lat;
    logic [31:0] expRdata;
    logic expRvalid;
    lat = (d == 0) ? 0 : 3;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      if (c == lat) driveBus(d, 1'b1, wen, addr, wdata, be, clr);
      else driveBus(d, 1'b1, 1'($urandom), 10'($urandom), $urandom, 4'($urandom), 1'b0);
      #1;
      checkOutput($sformatf("%s/ready_c%0d", name, c), getReady(d), {31'd0, c == lat});
    end
    @(posedge clk);
    #1;
    driveBus(d, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    modelAccess(d, wen, addr, wdata, be, clr, expRdata, expRvalid);
    if (useTable) begin
      expRdata  = tabRdata;
      expRvalid = tabRvalid;
    end
    checkOutput({name, "/rvalid"}, getRvalid(d), {31'd0, expRvalid});
    checkOutput({name, "/rdata"}, getRdata(d), expRdata);
    checkOutput({name, "/rdcnt"}, getRdCnt(d), 32'(satCnt(d, modelRd[d])));
    checkOutput({name, "/wrcnt"}, getWrCnt(d), 32'(satCnt(d, modelWr[d])));
  endtask

  task automatic idleCycle(input int d, input string name);
    @(negedge clk);
    driveBus(d, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput({name, "/idle_rvalid"}, getRvalid(d), 32'd0);
    checkOutput({name, "/idle_rdata"}, getRdata(d), modelRdata[d]);
    if (d == 1) checkOutput({name, "/idle_ready"}, getReady(d), 32'd0);
  endtask

  initial begin
    logic [31:0] wd;
    rstN = 1'b0;
    driveBus(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    driveBus(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      modelRdata[d] = '0; modelRd[d] = 0; modelWr[d] = 0;
    end

    vecs[0] = '{1'b1, 10'h005, 32'hDEADBEEF, 4'b1111, 32'h00000000, 1'b0};
    vecs[1] = '{1'b0, 10'h005, 32'h00000000, 4'b0000, 32'hDEADBEEF, 1'b1};
    vecs[2] = '{1'b1, 10'h006, 32'h11223344, 4'b1111, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b1, 10'h006, 32'hAABBCCDD, 4'b0101, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{1'b0, 10'h006, 32'h00000000, 4'b0000, 32'h11BB33DD, 1'b1};
    vecs[5] = '{1'b1, 10'h006, 32'hFFFFFFFF, 4'b0000, 32'h11BB33DD, 1'b0};
    vecs[6] = '{1'b0, 10'h006, 32'h00000000, 4'b1111, 32'h11BB33DD, 1'b1};
    vecs[7] = '{1'b0, 10'h005, 32'h00000000, 4'b1010, 32'hDEADBEEF, 1'b1};

    #1;
    checkOutput("reset/l0_rvalid", getRvalid(0), 32'd0);
    checkOutput("reset/l0_rdata", getRdata(0), 32'd0);
    checkOutput("reset/l0_rdcnt", getRdCnt(0), 32'd0);
    checkOutput("reset/l3_ready", getReady(1), 32'd0);
    checkOutput("reset/l3_rdata", getRdata(1), 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < 8; i++)
      applyStimulus(0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b0, 1'b1,
                    vecs[i].expRdata, vecs[i].expRvalid, $sformatf("l0_vec%0d", i));
    idleCycle(0, "l0_after_vec");

    for (int a = 0; a < 16; a++)
      applyStimulus(0, 1'b1, 10'(a + 16), $urandom, 4'hF, 1'b0, 1'b0, '0, 1'b0, $sformatf("l0_init%0d", a));
    for (int i = 0; i < 40; i++)
      applyStimulus(0, 1'($urandom), 10'(16 + $urandom_range(0, 15)), $urandom, 4'($urandom), 1'b0, 1'b0,
                    '0, 1'b0, $sformatf("l0_rand%0d", i));

    applyStimulus(0, 1'b0, 10'h005, '0, 4'h0, 1'b1, 1'b0, '0, 1'b0, "l0_clr_with_read");
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1'b0, 10'h006, '0, 4'h0, 1'b0, 1'b0, '0, 1'b0, $sformatf("l0_cntrd%0d", i));
    applyStimulus(0, 1'b1, 10'h007, 32'h0BADF00D, 4'hF, 1'b0, 1'b0, '0, 1'b0, "l0_cntwr");
`ifdef XBAR_MEM_ACCESS_CNT_EN
    checkOutput("cnt/rd_saturated", getRdCnt(0), 32'd3);
    checkOutput("cnt/wr_one", getWrCnt(0), 32'd1);
`else
    checkOutput("cnt/rd_tied_zero", getRdCnt(0), 32'd0);
    checkOutput("cnt/wr_tied_zero", getWrCnt(0), 32'd0);
`endif

    applyStimulus(1, 1'b1, 10'h005, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, '0, 1'b0, "l3_wr");
    applyStimulus(1, 1'b0, 10'h005, '0, 4'h0, 1'b0, 1'b0, '0, 1'b0, "l3_rd");
    idleCycle(1, "l3_after_rd");
    for (int a = 0; a < 8; a++)
      applyStimulus(1, 1'b1, 10'(a + 32), $urandom, 4'hF, 1'b0, 1'b0, '0, 1'b0, $sformatf("l3_init%0d", a));
    for (int i = 0; i < 12; i++)
      applyStimulus(1, 1'($urandom), 10'(32 + $urandom_range(0, 7)), $urandom, 4'($urandom), 1'b0, 1'b0,
                    '0, 1'b0, $sformatf("l3_rand%0d", i));

    applyStimulus(1, 1'b1, 10'h020, 32'h12345678, 4'hF, 1'b0, 1'b0, '0, 1'b0, "l3_abort_setup");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      driveBus(1, 1'b1, 1'b1, 10'h020, 32'hFFFFFFFF, 4'hF, 1'b0);
      #1;
      checkOutput($sformatf("abort/ready_c%0d", c), getReady(1), 32'd0);
    end
    idleCycle(1, "abort_drop");
    applyStimulus(1, 1'b0, 10'h020, '0, 4'h0, 1'b0, 1'b0, '0, 1'b0, "abort_full_retry");
    checkOutput("abort/mem_kept", getRdata(1), 32'h12345678);

    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      driveBus(1, 1'b1, 1'b0, 10'h005, '0, 4'h0, 1'b0);
    end
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midreset/l3_ready", getReady(1), 32'd0);
    checkOutput("midreset/l3_rvalid", getRvalid(1), 32'd0);
    checkOutput("midreset/l3_rdata", getRdata(1), 32'd0);
    checkOutput("midreset/l0_rdata", getRdata(0), 32'd0);
    checkOutput("midreset/l0_rdcnt", getRdCnt(0), 32'd0);
    driveBus(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      modelRdata[d] = '0; modelRd[d] = 0; modelWr[d] = 0;
    end
    @(negedge clk);
    rstN = 1'b1;
    idleCycle(1, "postreset");
    applyStimulus(1, 1'b0, 10'h020, '0, 4'h0, 1'b0, 1'b0, '0, 1'b0, "postreset_l3_rd");
    checkOutput("postreset/l3_retained", getRdata(1), 32'h12345678);
    applyStimulus(0, 1'b0, 10'h005, '0, 4'h0, 1'b0, 1'b0, '0, 1'b0, "postreset_l0_rd");
    checkOutput("postreset/l0_retained", getRdata(0), 32'hDEADBEEF);
    wd = 32'h5A5AA5A5;
    applyStimulus(0, 1'b1, 10'h008, wd, 4'hF, 1'b0, 1'b0, '0, 1'b0, "raw_wr");
    applyStimulus(0, 1'b0, 10'h008, '0, 4'h0, 1'b0, 1'b0, '0, 1'b0, "raw_rd");
    checkOutput("raw/new_data", getRdata(0), wd);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end
endmodule
